symbol_ram_write_control: RTL and testbench
===========================================

Name: symbol_RAM_write_control

Overview:
Write-side counterpart to the symbol read path. Accepts single-symbol write requests from game logic and commits each one into a small on-chip symbol RAM. Each write uses a fixed setup / write / two-cycle-hold sequence, mirroring the read controller's two-cycle wait discipline. A registered read port lets downstream display/compare logic fetch stored symbols.

Parameters:
ADDR_W, 2, symbol address width (2^ADDR_W entries)
DATA_W, 7, symbol code width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
wr_req  input  1  write request, sampled only in IDLE
wr_addr  input  ADDR_W  write address, captured with wr_req
wr_data  input  DATA_W  write data, captured with wr_req
busy  output  1  high from cycle after acceptance through DONE
wr_done  output  1  one-cycle completion pulse
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  registered RAM[rd_addr]
verify_err  output  1  sticky readback mismatch flag (see Optional Feature)

Behaviour:
- Reset: one clock; rst asynchronous, active-high.
  - While rst is high: state=IDLE; busy=0; wr_done=0; rd_data=0; verify_err=0; latched addr/data=0; all RAM entries cleared to 0.
  - Reset mid-sequence aborts the write. No wr_done is issued.
- FSM states: IDLE, SETUP, WRITE, HOLD1, HOLD2, [VERIFY], DONE.
  - IDLE: if wr_req=1 at an edge, latch wr_addr and wr_data, go to SETUP; otherwise stay.
  - SETUP: RAM address driven from the latch, write enable low. Next state WRITE.
  - WRITE: write enable high for exactly one cycle, so RAM[latched addr] <= latched data. Next state HOLD1.
  - HOLD1: next state HOLD2.
  - HOLD2: next state DONE, or VERIFY when the feature is enabled.
  - DONE: wr_done=1 for this cycle only. Next state IDLE.
- Timing (wr_req sampled at edge 0):
  - busy is high during cycles 1..5.
  - wr_done is high during cycle 5.
  - IDLE is reached in cycle 6.
- wr_req while busy: ignored, never queued. The captured address and data do not change mid-sequence.
- wr_req high in the first IDLE cycle after DONE: accepted, giving a back-to-back write period of 6 cycles.
- Read port:
  - Latency 1: rd_data <= RAM[rd_addr] every edge.
  - Read-first: a read of the address being written in the WRITE cycle returns the old value; the new value appears on the following read.
- Control outputs (busy, wr_done) are decoded from registered state only; no combinational path from inputs.

Optional Feature:
WRITE_VERIFY_EN
- Defined:
  - The VERIFY state is inserted after HOLD2.
  - In VERIFY, the RAM's second, asynchronous read port at the latched address is compared with the latched data.
  - On mismatch, verify_err is set. It stays set until reset or the next accepted wr_req, which clears it.
  - Timing becomes: busy in cycles 1..6, wr_done in cycle 6, write period 7.
- Undefined: no VERIFY state, verify_err tied to 0 (port still present), timing as in Behaviour.

Decomposition:
- Shared package/header:
  - ADDR_W and DATA_W defaults.
  - FSM state encodings.
  - SYM_CLEAR (7'h00) as the reset value.
- One sub-module, symbol_RAM:
  - 2^ADDR_W x DATA_W array with async clear.
  - Synchronous write port; registered read-first port (rd_addr/rd_data).
  - Second combinational read port, used only under WRITE_VERIFY_EN.
- The controller FSM and latches live in symbol_RAM_write_control.

Test Plan:
- Reset:
  - Stimulus: pulse rst, then sweep rd_addr 0..3.
  - Response: busy=0, wr_done=0, verify_err=0; rd_data=7'h00 for every address.
- Single write:
  - Stimulus: wr_req pulse at edge 0 with addr=2, data=7'h5A.
  - Response: busy high in cycles 1-5, wr_done only in cycle 5; then rd_addr=2 gives rd_data=7'h5A one cycle later, and addr 0, 1, 3 still read 7'h00.
- Request during busy:
  - Stimulus: start a write of addr=0, data=7'h21; in cycle 3 pulse wr_req with addr=1, data=7'h11.
  - Response: addr 0 reads 7'h21, addr 1 still reads 7'h00, only one wr_done.
- Back-to-back:
  - Stimulus: hold wr_req high with addr=3, data=7'h07, then change data to 7'h08 at cycle 6.
  - Response: second write accepted at edge 6, wr_done pulses in cycles 5 and 11, addr 3 finally reads 7'h08.
- Reset mid-write:
  - Stimulus: assert rst during HOLD1 of a write to addr=1, data=7'h33.
  - Response: busy drops immediately (asynchronous), no wr_done, addr 1 reads 7'h00.
- Read-first collision (under WRITE_VERIFY_EN):
  - Stimulus: rd_addr=3 held during a write of addr=3, data=7'h44 over an old value of 7'h12.
  - Response: rd_data=7'h12 in the cycle after WRITE, 7'h44 afterwards, wr_done in cycle 6, verify_err=0.

Source files
------------

// File: rtl/symbol_ram_write_control_pkg.sv
// Shared definitions for the symbol RAM write controller: default widths,
// FSM state encoding and the symbol value the RAM is cleared to on reset.
// Optional feature macro used by the bundle: WRITE_VERIFY_EN.
package symbol_ram_write_control_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 7;

  localparam logic [DATA_W_DEF-1:0] SYM_CLEAR = 7'h00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_HOLD1  = 3'd3,
    ST_HOLD2  = 3'd4,
    ST_VERIFY = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/symbol_ram_write_control_if.sv
// Write-request handshake plus the registered read port of the symbol RAM.
// master = game/display logic side, slave = the write controller.
interface symbol_ram_write_control_if
  import symbol_ram_write_control_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              wr_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              verify_err;

  modport master (
    output wr_req, wr_addr, wr_data, rd_addr,
    input  busy, wr_done, rd_data, verify_err
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_addr,
    output busy, wr_done, rd_data, verify_err
  );

endinterface

// File: rtl/symbol_ram_write_control_ram.sv
// Small symbol RAM: 2^ADDR_W x DATA_W, asynchronously cleared by rst.
// One synchronous write port, one registered read-first read port, and
// (only when WRITE_VERIFY_EN is defined) a combinational readback port.
module symbol_ram_write_control_ram
  import symbol_ram_write_control_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`ifdef WRITE_VERIFY_EN
  ,
  input  logic [ADDR_W-1:0] vf_addr,
  output logic [DATA_W-1:0] vf_data
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array: cleared on reset, written on the single WRITE-cycle enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(SYM_CLEAR);
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; samples the array before this edge's write lands,
  // so a same-address read during WRITE returns the previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= DATA_W'(SYM_CLEAR);
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

`ifdef WRITE_VERIFY_EN
  assign vf_data = mem[vf_addr];
`endif

endmodule

// File: rtl/symbol_ram_write_control.sv
// Symbol RAM write controller: accepts one write request at a time from IDLE
// and commits it with a setup / write / two-cycle-hold sequence, then pulses
// wr_done. busy and wr_done are decoded from the state register only.
// Optional feature macro: WRITE_VERIFY_EN inserts a VERIFY state that reads
// the written entry back and raises a sticky verify_err on mismatch.
module symbol_ram_write_control
  import symbol_ram_write_control_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  symbol_ram_write_control_if.slave   bus
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              accept;
  logic              ram_we;

  // A request is only looked at in IDLE; anything arriving while busy is dropped.
  assign accept = (state == ST_IDLE) && bus.wr_req;
  assign ram_we = (state == ST_WRITE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed walk through the write sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.wr_req) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = ST_HOLD1;
      ST_HOLD1:  state_nxt = ST_HOLD2;
`ifdef WRITE_VERIFY_EN
      ST_HOLD2:  state_nxt = ST_VERIFY;
`else
      ST_HOLD2:  state_nxt = ST_DONE;
`endif
      ST_VERIFY: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Address/data latch: captured once at acceptance, frozen for the sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr <= '0;
      lat_data <= '0;
    end else if (accept) begin
      lat_addr <= bus.wr_addr;
      lat_data <= bus.wr_data;
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.wr_done = (state == ST_DONE);

`ifdef WRITE_VERIFY_EN
  logic [DATA_W-1:0] vf_data;
  logic              verify_err;

  // Sticky readback flag: cleared by a new accepted request, set on mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      verify_err <= 1'b0;
    end else if (accept) begin
      verify_err <= 1'b0;
    end else if ((state == ST_VERIFY) && (vf_data != lat_data)) begin
      verify_err <= 1'b1;
    end
  end

  assign bus.verify_err = verify_err;
`else
  assign bus.verify_err = 1'b0;
`endif

  symbol_ram_write_control_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .wr_addr (lat_addr),
    .wr_data (lat_data),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
`ifdef WRITE_VERIFY_EN
    ,
    .vf_addr (lat_addr),
    .vf_data (vf_data)
`endif
  );

endmodule

// File: tb/tb_symbol_ram_write_control.sv
// Directed bench for the symbol RAM write controller: a vector table for the
// reset sweep and a single write, plus hand sequences for the multi-cycle
// cases (request while busy, back-to-back, reset mid-write, read-first).
module tb_symbol_ram_write_control;

`ifdef WRITE_VERIFY_EN
  localparam int DC = 6;   // cycle in which wr_done pulses
`else
  localparam int DC = 5;
`endif

  typedef struct {
    logic       req;
    logic [1:0] addr;
    logic [6:0] data;
    logic [1:0] raddr;
    logic       busy;
    logic       done;
    logic       chk_rd;
    logic [6:0] rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  symbol_ram_write_control_if bus ();

  symbol_ram_write_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_row(input logic req, input logic [1:0] addr, input logic [6:0] data,
                         input logic [1:0] raddr, input logic busy, input logic done,
                         input logic chk_rd, input logic [6:0] rd);
    vec_t v;
    v.req = req; v.addr = addr; v.data = data; v.raddr = raddr;
    v.busy = busy; v.done = done; v.chk_rd = chk_rd; v.rd = rd;
    tbl.push_back(v);
  endtask

  // Full write from IDLE; returns in the first IDLE cycle afterwards.
  task automatic do_write(input logic [1:0] addr, input logic [6:0] data);
    bus.wr_req  = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_req = 1'b0;
    repeat (DC) tick();
  endtask

  task automatic read_chk(input string nm, input logic [1:0] raddr, input logic [6:0] exp);
    bus.rd_addr = raddr;
    tick();
    chk(nm, bus.rd_data, exp);
  endtask

  initial begin
    int cnt;

    rst         = 1'b1;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.wr_done, 1'b0);
    chk("rst_verr", bus.verify_err, 1'b0);
    chk("rst_rd", bus.rd_data, 7'h00);
    rst = 1'b0;
    tick();

    // Reset sweep of all addresses.
    for (int a = 0; a < 4; a++) add_row(1'b0, 2'd0, 7'h00, 2'(a), 1'b0, 1'b0, 1'b1, 7'h00);
    // Single write addr 2 <= 5A; row i leaves the bench in cycle i+1.
    for (int i = 0; i < DC; i++)
      add_row(i == 0, 2'd2, 7'h5A, 2'd0, 1'b1, (i + 1) == DC, 1'b1, 7'h00);
    add_row(1'b0, 2'd0, 7'h00, 2'd2, 1'b0, 1'b0, 1'b1, 7'h5A);
    add_row(1'b0, 2'd0, 7'h00, 2'd0, 1'b0, 1'b0, 1'b1, 7'h00);
    add_row(1'b0, 2'd0, 7'h00, 2'd1, 1'b0, 1'b0, 1'b1, 7'h00);
    add_row(1'b0, 2'd0, 7'h00, 2'd3, 1'b0, 1'b0, 1'b1, 7'h00);

    foreach (tbl[i]) begin
      bus.wr_req  = tbl[i].req;
      bus.wr_addr = tbl[i].addr;
      bus.wr_data = tbl[i].data;
      bus.rd_addr = tbl[i].raddr;
      tick();
      chk($sformatf("v%0d_busy", i), bus.busy, tbl[i].busy);
      chk($sformatf("v%0d_done", i), bus.wr_done, tbl[i].done);
      chk($sformatf("v%0d_verr", i), bus.verify_err, 1'b0);
      if (tbl[i].chk_rd) chk($sformatf("v%0d_rd", i), bus.rd_data, tbl[i].rd);
    end
    bus.wr_req = 1'b0;

    // Request while busy: the addr 1 request in cycle 3 must be dropped.
    cnt = 0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 2'd0;
    bus.wr_data = 7'h21;
    for (int c = 1; c <= DC + 6; c++) begin
      tick();
      if (bus.wr_done) begin
        cnt++;
        chk("ign_done_cycle", c, DC);
      end
      if (c == 1) bus.wr_req = 1'b0;
      if (c == 3) begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = 2'd1;
        bus.wr_data = 7'h11;
      end
      if (c == 4) bus.wr_req = 1'b0;
    end
    chk("ign_done_count", cnt, 1);
    read_chk("ign_rd_a0", 2'd0, 7'h21);
    read_chk("ign_rd_a1", 2'd1, 7'h00);
    read_chk("ign_rd_a2", 2'd2, 7'h5A);

    // Back-to-back: request held high, data switched in the first IDLE cycle.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 2'd3;
    bus.wr_data = 7'h07;
    for (int c = 1; c <= 2 * DC + 4; c++) begin
      tick();
      chk($sformatf("b2b_done_c%0d", c), bus.wr_done, (c == DC) || (c == 2 * DC + 1));
      chk($sformatf("b2b_busy_c%0d", c), bus.busy, !((c == DC + 1) || (c > 2 * DC + 1)));
      if (c == DC + 1) bus.wr_data = 7'h08;
      if (c == DC + 2) bus.wr_req = 1'b0;
    end
    read_chk("b2b_rd_a3", 2'd3, 7'h08);

    // Reset asserted asynchronously during HOLD1 of a write to addr 1.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 2'd1;
    bus.wr_data = 7'h33;
    tick();
    bus.wr_req = 1'b0;
    tick();
    tick();
    chk("mid_busy_pre", bus.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_busy_async", bus.busy, 1'b0);
    chk("mid_done_async", bus.wr_done, 1'b0);
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < DC + 3; c++) begin
      tick();
      if (bus.wr_done) cnt++;
    end
    chk("mid_no_done", cnt, 0);
    read_chk("mid_rd_a1", 2'd1, 7'h00);
    read_chk("mid_rd_a3", 2'd3, 7'h00);

    // Read-first collision: rd_addr held on the entry being rewritten.
    do_write(2'd3, 7'h12);
    bus.rd_addr = 2'd3;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 2'd3;
    bus.wr_data = 7'h44;
    for (int c = 1; c <= DC + 1; c++) begin
      tick();
      chk($sformatf("col_rd_c%0d", c), bus.rd_data, (c <= 3) ? 7'h12 : 7'h44);
      chk($sformatf("col_done_c%0d", c), bus.wr_done, c == DC);
      chk($sformatf("col_busy_c%0d", c), bus.busy, c <= DC);
      if (c == 1) bus.wr_req = 1'b0;
    end
    chk("col_verr", bus.verify_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
